moore_seq_det: RTL and testbench

MOORE_SEQ_DET -- requirements
Module: moore_seq_det

---
 rtl/moore_seq_det_pkg.sv | 21 ++
 rtl/moore_seq_det_cnt.sv | 39 +++
 rtl/moore_seq_det.sv | 104 ++++++++++
 tb/tb_moore_seq_det.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_det_pkg.sv
// Shared constants and helpers for the moore_seq_det serial pattern detector.
// The match counter is built only when MOORE_SEQ_DET_CNT_EN is defined.
package moore_seq_det_pkg;

    // Legal pattern length range.
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    // Legal match counter width range.
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    // Power-on value of the pattern register for the default 3-bit pattern.
    localparam logic [2:0] DEFAULT_PATTERN = 3'b010;

    // Width needed to count 0..pat_len valid history bits.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/moore_seq_det_cnt.sv
// Saturating match counter for moore_seq_det. Clear wins over increment, and
// the count sticks at all-ones instead of wrapping back to zero.
module moore_seq_det_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        // NOTE: the default assignment comes first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/moore_seq_det.sv
// Moore serial pattern detector: shifts valid bits into a history register,
// tracks how many history bits are valid, and flags a match decoded only from
// registered state. The match counter is present only when
// MOORE_SEQ_DET_CNT_EN is defined; otherwise match_cnt is tied to zero.
module moore_seq_det
    import moore_seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                FILL_W  = fill_width(PAT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clear,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [FILL_W-1:0]  fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] pat_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               match;
    logic               cnt_inc;

    // The match flag only looks at flops, so no input reaches out combinationally.
    assign match = (fill_q == FILL_FULL) && (hist_q == pat_q);

    // Next history, fill and pattern; flags the edges that land in a match state.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        cnt_inc = 1'b0;

        if (pat_load) begin
            pat_d = pat_in;
        end

        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (pat_load) begin
            // A new pattern restarts detection; a sample on the same edge is dropped.
            fill_d = '0;
        end else if (in_valid) begin
            if ((OVERLAP == 0) && match) begin
                // Non-overlapping: the bit after a match starts a fresh window.
                hist_d = PAT_LEN'(in);
                fill_d = FILL_W'(1);
            end else begin
                hist_d = {hist_q[PAT_LEN-2:0], in};
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            cnt_inc = (fill_d == FILL_FULL) && (hist_d == pat_q);
        end
    end

    // History, fill and pattern registers; reset reloads the power-on pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

    assign out  = match;
    assign fill = fill_q;

`ifdef MOORE_SEQ_DET_CNT_EN
    moore_seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (cnt_inc),
        .cnt   (match_cnt)
    );
`else
    logic unused_cnt_inc;
    assign unused_cnt_inc = cnt_inc;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: three instances (overlap, non-overlap, 2-bit
// saturating counter) share one stimulus stream. A queue-based model of the
// received bits predicts each result; MOORE_SEQ_DET_CNT_EN selects whether a
// live counter is expected.
module tb_moore_seq_det;

`ifdef MOORE_SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       din;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       clear;

    logic       out_ov, out_no, out_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;
    logic [1:0] fill_ov, fill_no, fill_sat;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    moore_seq_det #(.PAT_LEN(3), .PATTERN(3'b010), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clear(clear), .out(out_ov), .match_cnt(cnt_ov), .fill(fill_ov));

    moore_seq_det #(.PAT_LEN(3), .PATTERN(3'b010), .OVERLAP(0), .CNT_W(8)) u_no (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clear(clear), .out(out_no), .match_cnt(cnt_no), .fill(fill_no));

    moore_seq_det #(.PAT_LEN(3), .PATTERN(3'b010), .OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .pat_load(pat_load),
        .pat_in(pat_in), .clear(clear), .out(out_sat), .match_cnt(cnt_sat), .fill(fill_sat));

    // Observed outputs, index 0 = overlap, 1 = non-overlap, 2 = saturating.
    logic [2:0]      o_out;
    logic [2:0][3:0] o_fill;
    logic [2:0][7:0] o_cnt;
    assign o_out  = {out_sat, out_no, out_ov};
    assign o_fill = {{2'b00, fill_sat}, {2'b00, fill_no}, {2'b00, fill_ov}};
    assign o_cnt  = {{6'b0, cnt_sat}, cnt_no, cnt_ov};

    // Reference model: bits received since the last restart, newest at the back.
    bit         mq[3][$];
    int         m_cnt[3];
    logic [2:0] m_pat;
    int         m_ov[3]  = '{1, 0, 1};
    int         m_max[3] = '{255, 255, 3};

    typedef struct packed {
        logic [2:0]      out;
        logic [2:0][3:0] fill;
        logic [2:0][7:0] cnt;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit model_match(input int i);
        if (mq[i].size() != 3) return 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (mq[i][k] != m_pat[2-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_cnt[i] = 0;
        end
        m_pat = 3'b010;
    endtask

    task automatic model_step(input logic v, input logic b, input logic ld,
                              input logic [2:0] pin, input logic clr);
        for (int i = 0; i < 3; i++) begin
            bit was;
            was = model_match(i);
            if (clr) begin
                mq[i].delete();
                m_cnt[i] = 0;
            end else if (ld) begin
                mq[i].delete();
            end else if (v) begin
                if (m_ov[i] == 0 && was) mq[i].delete();
                mq[i].push_back(b);
                if (mq[i].size() > 3) void'(mq[i].pop_front());
                if (model_match(i) && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end
        end
        if (ld) m_pat = pin;
    endtask

    task automatic push_expected(input string tag);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.out[i]  = model_match(i);
            e.fill[i] = 4'(mq[i].size());
            e.cnt[i]  = CNT_EN ? 8'(m_cnt[i]) : 8'd0;
        end
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic compare_expected();
        exp_t  e;
        string tag;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e   = sb.pop_front();
        tag = sb_tag.pop_front();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s out%0d", tag, i),  {31'b0, o_out[i]},  {31'b0, e.out[i]});
            check($sformatf("%s fill%0d", tag, i), {28'b0, o_fill[i]}, {28'b0, e.fill[i]});
            check($sformatf("%s cnt%0d", tag, i),  {24'b0, o_cnt[i]},  {24'b0, e.cnt[i]});
        end
    endtask

    task automatic check_now(input string tag);
        push_expected(tag);
        compare_expected();
    endtask

    // One clock of stimulus: drive, predict, wait past the edge, compare.
    task automatic step(input logic v, input logic b, input logic ld,
                        input logic [2:0] pin, input logic clr, input string tag);
        in_valid = v;
        din      = b;
        pat_load = ld;
        pat_in   = pin;
        clear    = clr;
        model_step(v, b, ld, pin, clr);
        push_expected(tag);
        @(posedge clk);
        #1;
        compare_expected();
    endtask

    // Valid samples, MSB of bits first; pat_in wiggles to show it is ignored.
    task automatic feed(input logic [15:0] bits, input int n, input string tag);
        for (int k = n - 1; k >= 0; k--) begin
            step(1'b1, bits[k], 1'b0, 3'($urandom_range(0, 7)), 1'b0,
                 $sformatf("%s b%0d", tag, n - 1 - k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tr_ov, tr_no, tr_sat;

        reset    = 1'b0;
        in_valid = 1'b0;
        din      = 1'b0;
        pat_load = 1'b0;
        pat_in   = 3'b111;
        clear    = 1'b0;
        model_reset();
        #12;
        check_now("reset_state");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream 0,1,1,0,1,0,1,0 with out traces collected per sample.
        tr_ov  = '0;
        tr_no  = '0;
        tr_sat = '0;
        begin
            logic [7:0] s;
            s = 8'b01101010;
            for (int k = 7; k >= 0; k--) begin
                step(1'b1, s[k], 1'b0, 3'($urandom_range(0, 7)), 1'b0, $sformatf("basic b%0d", 7 - k));
                tr_ov  = {tr_ov[6:0], out_ov};
                tr_no  = {tr_no[6:0], out_no};
                tr_sat = {tr_sat[6:0], out_sat};
            end
        end
        check("trace_overlap", {24'b0, tr_ov}, 32'b00000101);
        check("trace_nonoverlap", {24'b0, tr_no}, 32'b00000100);
        check("trace_sat", {24'b0, tr_sat}, 32'b00000101);
        check("cnt_overlap_final", {24'b0, cnt_ov}, CNT_EN ? 32'd2 : 32'd0);
        check("cnt_nonoverlap_final", {24'b0, cnt_no}, CNT_EN ? 32'd1 : 32'd0);

        // Clear, then the same stream with a five-cycle idle gap after sample 5.
        step(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, "clear1");
        feed(16'b01101, 5, "gap_pre");
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)), 1'b0,
                 $sformatf("gap idle%0d", g));
        end
        feed(16'b010, 3, "gap_post");
        check("gap_cnt_overlap", {24'b0, cnt_ov}, CNT_EN ? 32'd2 : 32'd0);

        // Saturation: four overlapping matches against a 2-bit counter.
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "clear2");
        feed(16'b0101010101, 10, "sat");
        check("sat_cnt_final", {30'b0, cnt_sat}, CNT_EN ? 32'd3 : 32'd0);

        // Pattern load discards the coincident sample and empties the history.
        step(1'b1, 1'b1, 1'b1, 3'b110, 1'b0, "load110");
        check("load_fill_zero", {30'b0, fill_ov}, 32'd0);
        feed(16'b110, 3, "pat110");
        check("pat110_match", {31'b0, out_ov}, 32'd1);

        // Clear during a match, then clear together with a pattern reload.
        step(1'b1, 1'b1, 1'b0, 3'b011, 1'b1, "clear_in_match");
        check("clear_out_zero", {31'b0, out_ov}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, "clear_and_load");
        feed(16'b010, 3, "pat010");

        // Asynchronous reset in the middle of a match.
        reset = 1'b0;
        #1;
        model_reset();
        check_now("async_rst");
        check("async_rst_out", {31'b0, out_ov}, 32'd0);
        #4;
        reset = 1'b1;

        // A partial match before reset must not carry over.
        feed(16'b01, 2, "partial");
        reset = 1'b0;
        #1;
        model_reset();
        check_now("async_rst2");
        #4;
        reset = 1'b1;
        feed(16'b0, 1, "restart");
        check("restart_no_match", {31'b0, out_ov}, 32'd0);
        feed(16'b10, 2, "restart_tail");
        check("restart_match", {31'b0, out_ov}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
